// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// Holds the state enum, opcodes, ALU/mux select encodings and the control bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WRITE,
    S_MEM_WB,
    S_EXEC_R,
    S_R_WB,
    S_ADDI_EX,
    S_ADDI_WB,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } mc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_FOUR = 2'd1;
  localparam logic [1:0] ALUB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal_op;
    logic       busy;
  } mc_ctrl_t;

  // Last state of every class except MEM_WRITE, which also needs mem_ready.
  function automatic logic is_wb_end(mc_state_e s);
    return (s == S_MEM_WB)  || (s == S_R_WB) ||
           (s == S_ADDI_WB) || (s == S_BRANCH) ||
           (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control decode for the multi-cycle MIPS FSM.
// Ports: state_i, mem_ready_i, zero_i in; ctrl_o control bundle out.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  mc_state_e state_i,
  input  logic      mem_ready_i,
  input  logic      zero_i,
  output mc_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (1'b1)
      (state_i == S_FETCH): begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC load only once the word arrives.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      (state_i == S_DECODE): begin
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      (state_i == S_MEM_ADDR),
      (state_i == S_ADDI_EX): begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      (state_i == S_MEM_READ): begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      (state_i == S_MEM_WRITE): begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      (state_i == S_MEM_WB): begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      (state_i == S_EXEC_R): begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REG;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      (state_i == S_R_WB): begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      (state_i == S_ADDI_WB): begin
        ctrl_o.reg_write = 1'b1;
      end
      (state_i == S_BRANCH): begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUB_REG;
        ctrl_o.alu_op        = ALU_OP_SUB;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = zero_i;
      end
      (state_i == S_JUMP): begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      (state_i == S_ILLEGAL): begin
        ctrl_o.illegal_op = 1'b1;
      end
      default: ;
    endcase
    ctrl_o.busy = (state_i != S_IDLE);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, next-state, optional perf counters.
// Ports: clk, rst_n, en, opcode, zero, mem_ready in; datapath selects/enables out. Macro: MC_CTRL_PERF_EN.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             illegal_op,
`ifdef MC_CTRL_PERF_EN
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic             busy
);

  mc_state_e state_q, state_d;
  mc_state_e end_st;
  mc_ctrl_t  ctrl;

  // Instruction boundary: en decides whether we keep running.
  assign end_st = en ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (en) state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_RTYPE): state_d = S_EXEC_R;
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MEM_ADDR;
          (opcode == OP_BEQ):   state_d = S_BRANCH;
          (opcode == OP_J):     state_d = S_JUMP;
          (opcode == OP_ADDI):  state_d = S_ADDI_EX;
          default:              state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = end_st;
      S_EXEC_R:    state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_MEM_WB,
      S_R_WB,
      S_ADDI_WB,
      S_BRANCH,
      S_JUMP,
      S_ILLEGAL:   state_d = end_st;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (ctrl)
  );

  assign mem_req       = ctrl.mem_req;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign illegal_op    = ctrl.illegal_op;
  assign busy          = ctrl.busy;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             instr_end;

  // ILLEGAL ends an instruction but is not counted.
  assign instr_end = is_wb_end(state_q) ||
                     ((state_q == S_MEM_WRITE) && mem_ready);

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (instr_end)
      instr_cnt_d = instr_cnt_q + 1'b1;
    if (ctrl.mem_req && !mem_ready)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_count = instr_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
